uart_rx_buffer: RTL and testbench
=================================

UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; power of two, 4..64.
REQ-002 Parameter ADDR_W, default 4, pointer width; log2(DEPTH).
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_data  input  8  byte from the UART receiver; valid only while in_valid=1.
REQ-006 in_valid  input  1  one-cycle pulse per received byte.
REQ-007 out_ready  input  1  consumer can take a byte this cycle (driven from !tx_busy by the setting/input stages).
REQ-008 flush  input  1  discard all buffered bytes (driven by clear_rx_buffer).
REQ-009 rx_data  output  8  last popped byte; held stable between pops.
REQ-010 rx_done  output  1  one-cycle pulse; rx_data is new this cycle.
REQ-011 count  output  ADDR_W+1  bytes currently stored, 0..DEPTH.
REQ-012 empty / full  output  1 each  count==0 / count==DEPTH, combinational from count.
REQ-013 overflow  output  1  sticky; a byte was dropped because the FIFO was full.

Function
REQ-014 The block SHALL store accepted bytes in a DEPTH-entry circular FIFO with ADDR_W-bit read/write pointers that wrap from DEPTH-1 to 0.
REQ-015 Write: the block SHALL store in_data at the clk edge where in_valid=1, flush=0, and (not full or a pop occurs at the same edge).
REQ-016 Pop: at any edge with out_ready=1, count>0 and flush=0, the block SHALL load rx_data from the read pointer, advance the pointer, and drive rx_done=1 for exactly the following cycle.
REQ-017 rx_done SHALL be 0 in every cycle not immediately after a pop; consecutive pops SHALL give back-to-back pulses while out_ready stays 1.
REQ-018 Latency: a byte written to an empty FIFO at edge N, with out_ready=1, SHALL appear with rx_done=1 after edge N+1. No bypass of the FIFO is allowed.
REQ-019 Simultaneous write and pop SHALL leave count unchanged and lose no byte, including when full.
REQ-020 Write while full with no pop SHALL drop in_data, leave the FIFO unchanged, and set overflow.
REQ-021 Pop while empty SHALL have no effect; rx_done stays 0 and rx_data holds.
REQ-022 flush=1 SHALL, at that edge, zero both pointers, count, rx_done and overflow and retain rx_data; flush takes priority over any write or pop at the same edge.
REQ-023 Bytes SHALL be delivered in arrival order with no duplication.

Reset
REQ-024 While rst=1, asynchronously: pointers=0, count=0, rx_data=8'h00, rx_done=0, overflow=0, so empty=1 and full=0. FIFO memory contents are don't-care.
REQ-025 rst asserted mid-stream SHALL discard all stored bytes; the first in_valid after deassertion is stored at entry 0.

Configuration
REQ-026 Macro RX_BUF_FILTER_EN: when defined, bytes 8'h0D, 8'h0A and any byte <8'h20 other than 8'h20 itself SHALL be discarded before the write. Filtered bytes do not count as writes and never set overflow.
REQ-027 When RX_BUF_FILTER_EN is undefined, every in_valid byte is a write candidate per REQ-015. The port list is identical in both builds.

Verification
REQ-028 Reset, then in_valid with "3" and out_ready=1 -> rx_done pulse 2 edges later with rx_data=8'h33, count returns to 0.
REQ-029 out_ready=0, write 17 bytes 0x41..0x51 (DEPTH=16) -> full=1, overflow=1, count=16; raise out_ready -> 16 pulses 0x41..0x50 back-to-back, then empty=1.
REQ-030 Full FIFO, in_valid=1 and out_ready=1 at the same edge -> count stays 16, overflow stays 0, new byte is delivered last.
REQ-031 Load 5 bytes, assert flush together with in_valid -> count=0, overflow=0, rx_done=0, rx_data unchanged, the concurrent byte is not stored.
REQ-032 With RX_BUF_FILTER_EN defined, send "1",0x0D,0x0A," " -> only 0x31 and 0x20 are delivered. Without the macro -> all four bytes are delivered.
REQ-033 Pointer wrap: 40 bytes streamed through with random out_ready -> output order equals input order; rst pulse mid-stream -> count=0, next byte is delivered first.

Source files
------------

// File: rtl/uart_rx_buffer.sv
// ============================================================================
// Module   : uart_rx_buffer
// Purpose  : Receive-side byte FIFO between a UART receiver and its consumer.
//            Optional control-character filter enabled by RX_BUF_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              out_ready,
    input  logic              flush,
    output logic [7:0]        rx_data,
    output logic              rx_done,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overflow
);

    localparam logic [ADDR_W:0] c_DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] c_ONE       = (ADDR_W+1)'(1);

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [7:0]        r_rx_data;
    logic              r_rx_done;
    logic              r_overflow;

    logic w_filtered;
    logic w_accept;
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_write;
    logic w_drop;

    // Filtered bytes vanish before the FIFO sees them: no write, no overflow.
`ifdef RX_BUF_FILTER_EN
    assign w_filtered = (in_data < 8'h20);
`else
    assign w_filtered = 1'b0;
`endif

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_DEPTH_CNT);
    assign w_accept = in_valid && !w_filtered && !flush;
    assign w_pop    = out_ready && !w_empty && !flush;
    assign w_write  = w_accept && (!w_full || w_pop);
    assign w_drop   = w_accept && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rx_data  <= 8'h00;
            r_rx_done  <= 1'b0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            // rx_data is deliberately retained across a flush.
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rx_done  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_rx_done <= w_pop;
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_rx_data <= r_mem[r_rd_ptr];
            end
            if (w_write && !w_pop) begin
                r_count <= r_count + c_ONE;
            end else if (w_pop && !w_write) begin
                r_count <= r_count - c_ONE;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign rx_data  = r_rx_data;
    assign rx_done  = r_rx_done;
    assign count    = r_count;
    assign empty    = w_empty;
    assign full     = w_full;
    assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_buffer.sv
// ============================================================================
// Module   : tb_uart_rx_buffer
// Purpose  : Queue-based reference model with per-cycle comparison of
//            uart_rx_buffer outputs, directed scenarios and random traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_buffer;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic              flush = 1'b0;
    logic [7:0]        rx_data;
    logic              rx_done;
    logic [ADDR_W:0]   count;
    logic              empty;
    logic              full;
    logic              overflow;

    always #5 clk = ~clk;

    uart_rx_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .out_ready(out_ready), .flush(flush), .rx_data(rx_data),
        .rx_done(rx_done), .count(count), .empty(empty), .full(full),
        .overflow(overflow)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0] mq[$];
    logic [7:0] m_acc[$];
    logic [7:0] m_data = 8'h00;
    logic       m_done = 1'b0;
    logic       m_ovf  = 1'b0;
    bit         chk_en = 1'b0;
    logic [7:0] got[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_filtered(input logic [7:0] d);
`ifdef RX_BUF_FILTER_EN
        return (d < 8'h20);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        mq.delete();
        m_data = 8'h00;
        m_done = 1'b0;
        m_ovf  = 1'b0;
    endtask

    // Applies the inputs present at a rising edge to the queue model.
    task automatic model_step();
        bit pop;
        bit acc;
        if (rst) begin
            model_reset();
            return;
        end
        pop = out_ready && (mq.size() > 0) && !flush;
        acc = in_valid && !is_filtered(in_data);
        if (flush) begin
            mq.delete();
            m_done = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            m_done = pop;
            if (pop) m_data = mq.pop_front();
            if (acc) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(in_data);
                    m_acc.push_back(in_data);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("count",    32'(count),    32'(mq.size()));
            check("empty",    32'(empty),    32'(mq.size() == 0));
            check("full",     32'(full),     32'(mq.size() == DEPTH));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("rx_done",  32'(rx_done),  32'(m_done));
            check("rx_data",  32'(rx_data),  32'(m_data));
            if (rx_done === 1'b1) got.push_back(rx_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        int         ndone;
        @(negedge clk);
        #1;
        do_reset();
        chk_en = 1'b1;
        tick();
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full",  32'(full),  0);
        check("rst_data",  32'(rx_data), 0);

        // Single byte, two-edge latency
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h33;
        tick();
        idle();
        check("lat_e1_done",  32'(rx_done), 0);
        check("lat_e1_count", 32'(count), 1);
        tick();
        check("lat_e2_done",  32'(rx_done), 1);
        check("lat_e2_data",  32'(rx_data), 32'h33);
        check("lat_e2_count", 32'(count), 0);
        tick();
        check("lat_e3_done",  32'(rx_done), 0);

        // Overflow: 17 writes with consumer stalled, then drain
        out_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h41 + i);
            tick();
        end
        idle();
        check("ovf_full",  32'(full), 1);
        check("ovf_flag",  32'(overflow), 1);
        check("ovf_count", 32'(count), 16);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("drain_done", 32'(rx_done), 1);
            check("drain_data", 32'(rx_data), 32'(8'h41 + i));
        end
        tick();
        check("drain_empty", 32'(empty), 1);
        check("drain_idle",  32'(rx_done), 0);

        // Full FIFO with simultaneous write and pop
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h60 + i);
            tick();
        end
        in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b1;
        tick();
        idle();
        check("fullrw_count", 32'(count), 16);
        check("fullrw_ovf",   32'(overflow), 0);
        check("fullrw_data",  32'(rx_data), 32'h60);
        for (int i = 0; i < 16; i++) tick();
        check("fullrw_last", 32'(rx_data), 32'h99);
        check("fullrw_empty", 32'(empty), 1);

        // Flush with a concurrent write
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
        tick();
        idle();
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h10 + i);
            tick();
        end
        check("pre_flush_count", 32'(count), 5);
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
        tick();
        idle();
        check("flush_count", 32'(count), 0);
        check("flush_ovf",   32'(overflow), 0);
        check("flush_done",  32'(rx_done), 0);
        check("flush_data",  32'(rx_data), 32'h5A);
        tick();
        check("flush_after_done",  32'(rx_done), 0);
        check("flush_after_empty", 32'(empty), 1);

        // Control-character sequence
        do_reset();
        got.delete();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'h31; tick();
        in_data = 8'h0D; tick();
        in_data = 8'h0A; tick();
        in_data = 8'h20; tick();
        idle();
        for (int i = 0; i < 4; i++) tick();
`ifdef RX_BUF_FILTER_EN
        check("filt_n", 32'(got.size()), 2);
        if (got.size() == 2) begin
            check("filt_0", 32'(got[0]), 32'h31);
            check("filt_1", 32'(got[1]), 32'h20);
        end
`else
        check("filt_n", 32'(got.size()), 4);
        if (got.size() == 4) begin
            check("filt_0", 32'(got[0]), 32'h31);
            check("filt_1", 32'(got[1]), 32'h0D);
            check("filt_2", 32'(got[2]), 32'h0A);
            check("filt_3", 32'(got[3]), 32'h20);
        end
`endif

        // 40-byte stream with random back-pressure
        do_reset();
        got.delete();
        m_acc.delete();
        for (int i = 0; i < 40; i++) begin
            b = 8'($urandom_range(8'h20, 8'hFF));
            in_valid = 1'b1; in_data = b;
            out_ready = 1'($urandom_range(0, 3) != 0);
            tick();
        end
        idle();
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) tick();
        check("stream_n", 32'(got.size()), 32'(m_acc.size()));
        ndone = (got.size() < m_acc.size()) ? got.size() : m_acc.size();
        for (int i = 0; i < ndone; i++) check("stream_order", 32'(got[i]), 32'(m_acc[i]));

        // Reset mid-stream discards stored bytes
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = 8'(8'hA0 + i);
            tick();
        end
        idle();
        rst = 1'b1;
        #1;
        check("midrst_count", 32'(count), 0);
        model_reset();
        tick();
        rst = 1'b0;
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hC3;
        tick();
        idle();
        tick();
        check("midrst_done", 32'(rx_done), 1);
        check("midrst_data", 32'(rx_data), 32'hC3);

        // Unconstrained random traffic including flushes and control bytes
        for (int i = 0; i < 3000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            out_ready = 1'($urandom_range(0, 2) == 0);
            flush     = 1'($urandom_range(0, 99) == 0);
            tick();
        end
        idle();
        tick();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
